// File: rtl/sar_conv_ctrl_pkg.sv
// Shared types and defaults for the successive-approximation conversion controller.
// Holds the FSM state encoding and the one-hot trial-bit helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        WAIT,
        DONE
    } sar_state_e;

    localparam int SAR_N_BITS      = 8;
    localparam int SAR_CMP_TIMEOUT = 15;

    // One-hot trial bit; callers truncate to their own resolution (at most 16 bits).
    function automatic logic [15:0] trialBit(input int idx);
        trialBit = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/sar_conv_ctrl_if.sv
// Sequencer handshake, comparator and result signals of the SAR controller.
// The master side is the controller itself; the slave side is its environment.
interface sar_conv_ctrl_if
    import sar_pkg::*;
#(
    parameter int N_BITS = SAR_N_BITS
);

    logic              start;
    logic              eoc;
    logic              cmp_trig;
    logic              cmp_valid;
    logic              cmp_out;
    logic [N_BITS-1:0] dac_code;
    logic [N_BITS-1:0] dout;
    logic              dout_valid;
    logic              timeout_err;

    modport master (
        input  start,
        input  cmp_valid,
        input  cmp_out,
        output cmp_trig,
        output dac_code,
        output dout,
        output dout_valid,
        output eoc,
        output timeout_err
    );

    modport slave (
        output start,
        output cmp_valid,
        output cmp_out,
        input  cmp_trig,
        input  dac_code,
        input  dout,
        input  dout_valid,
        input  eoc,
        input  timeout_err
    );

endinterface

// File: rtl/sar_conv_ctrl_wait_timer.sv
// Per-bit comparator wait counter: cleared while triggering, counts during WAIT,
// saturates instead of wrapping, and flags the last allowed WAIT cycle.
module sar_wait_timer
    import sar_pkg::*;
#(
    parameter int CMP_TIMEOUT = SAR_CMP_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W      = $clog2(CMP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CMP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(CMP_TIMEOUT - 1);

    logic [CNT_W-1:0] r_waitCnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_waitCnt <= '0;
        end else if (i_enable && (r_waitCnt != CNT_MAX)) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_waitCnt == CNT_EXPIRE);

endmodule

// File: rtl/sar_conv_ctrl.sv
// Successive-approximation conversion controller: walks the trial code MSB first,
// resolving each bit from the comparator and handshaking the result back via eoc.
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS      = SAR_N_BITS,
    parameter int CMP_TIMEOUT = SAR_CMP_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    sar_conv_ctrl_if.master bus
);

    localparam int               IDX_W   = $clog2(N_BITS);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N_BITS - 1);

    sar_state_e        r_state;
    logic              r_startQ;
    logic [N_BITS-1:0] r_dacCode;
    logic [IDX_W-1:0]  r_bitIdx;
    logic [N_BITS-1:0] r_dout;
    logic              r_doutValid;
    logic              r_eoc;
    logic              r_timeoutErr;

    sar_state_e        w_stateNext;
    logic [N_BITS-1:0] w_dacNext;
    logic [IDX_W-1:0]  w_bitIdxNext;
    logic [N_BITS-1:0] w_doutNext;
    logic              w_doutValidNext;
    logic              w_eocNext;
    logic              w_timeoutNext;
    logic [N_BITS-1:0] w_resolved;
    logic              w_decide;
    logic              w_bitValue;
    logic              w_startEdge;
    logic              w_expired;

    sar_wait_timer #(
        .CMP_TIMEOUT(CMP_TIMEOUT)
    ) u_waitTimer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == TRIG),
        .i_enable (r_state == WAIT),
        .o_expired(w_expired)
    );

    assign w_startEdge = bus.start && !r_startQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_startQ     <= 1'b0;
            r_dacCode    <= '0;
            r_bitIdx     <= '0;
            r_dout       <= '0;
            r_doutValid  <= 1'b0;
            r_eoc        <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_startQ     <= bus.start;
            r_dacCode    <= w_dacNext;
            r_bitIdx     <= w_bitIdxNext;
            r_dout       <= w_doutNext;
            r_doutValid  <= w_doutValidNext;
            r_eoc        <= w_eocNext;
            r_timeoutErr <= w_timeoutNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_dacNext       = r_dacCode;
        w_bitIdxNext    = r_bitIdx;
        w_doutNext      = r_dout;
        w_doutValidNext = 1'b0;
        w_eocNext       = r_eoc;
        w_timeoutNext   = r_timeoutErr;
        w_resolved      = r_dacCode;
        w_decide        = 1'b0;
        w_bitValue      = 1'b0;

        case (r_state)
            IDLE: begin
                w_eocNext = 1'b0;
                if (w_startEdge) begin
                    w_dacNext     = N_BITS'(trialBit(N_BITS - 1));
                    w_bitIdxNext  = IDX_MSB;
                    w_timeoutNext = 1'b0;
                    w_stateNext   = TRIG;
                end
            end

            TRIG: begin
                if (!bus.start) begin
                    w_dacNext   = '0;
                    w_stateNext = IDLE;
                end else begin
                    w_stateNext = WAIT;
                end
            end

            // A real decision beats a timeout landing on the same cycle.
            WAIT: begin
                if (!bus.start) begin
                    w_dacNext   = '0;
                    w_stateNext = IDLE;
                end else if (bus.cmp_valid) begin
                    w_decide   = 1'b1;
                    w_bitValue = bus.cmp_out;
                end else if (w_expired) begin
                    w_decide      = 1'b1;
                    w_bitValue    = 1'b0;
                    w_timeoutNext = 1'b1;
                end

                if (w_decide) begin
                    w_resolved[r_bitIdx] = w_bitValue;
                    if (r_bitIdx != '0) begin
                        w_dacNext    = w_resolved | N_BITS'(trialBit(int'(r_bitIdx) - 1));
                        w_bitIdxNext = r_bitIdx - IDX_W'(1);
                        w_stateNext  = TRIG;
                    end else begin
                        w_dacNext       = w_resolved;
                        w_doutNext      = w_resolved;
                        w_doutValidNext = 1'b1;
                        w_eocNext       = 1'b1;
                        w_stateNext     = DONE;
                    end
                end
            end

            // eoc drops on the same edge start falls, so the sequencer never re-samples a stale eoc.
            DONE: begin
                if (!bus.start) begin
                    w_eocNext   = 1'b0;
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.cmp_trig    = (r_state == TRIG);
    assign bus.dac_code    = r_dacCode;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_doutValid;
    assign bus.eoc         = r_eoc;
    assign bus.timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with an ideal comparator responder whose
// decision delay and withheld bit are set per conversion.
module tb_sar_conv_ctrl;

    localparam int N_BITS      = 8;
    localparam int CMP_TIMEOUT = 15;
    localparam int EDGE_LIMIT  = 400;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sar_conv_ctrl_if #(.N_BITS(N_BITS)) bus ();

    sar_conv_ctrl #(
        .N_BITS     (N_BITS),
        .CMP_TIMEOUT(CMP_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checkCount = 0;
    int         passCount  = 0;
    int         trigCount  = 0;
    int         cmpDelay   = 0;
    int         withholdIdx = -1;
    logic [7:0] vin        = 8'h00;
    logic [7:0] seqLog [16];
    logic [7:0] expSeq [8];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Ideal comparator: answers cmpDelay WAIT cycles late, or never for the withheld trigger.
    initial begin
        logic pending;
        int   cnt;
        pending       = 1'b0;
        cnt           = 0;
        bus.cmp_valid = 1'b0;
        bus.cmp_out   = 1'b0;
        forever begin
            @(negedge clk);
            bus.cmp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
                continue;
            end
            if (pending) begin
                if (cnt == 0) begin
                    bus.cmp_valid = 1'b1;
                    bus.cmp_out   = (vin >= bus.dac_code);
                    pending       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (bus.cmp_trig) begin
                if (trigCount < 16) seqLog[trigCount] = bus.dac_code;
                pending = (trigCount != withholdIdx);
                cnt     = cmpDelay;
                trigCount++;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] v, input int d, input int w);
        @(negedge clk);
        vin         = v;
        cmpDelay    = d;
        withholdIdx = w;
        trigCount   = 0;
        bus.start   = 1'b1;
        @(posedge clk);
    endtask

    task automatic waitEoc(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bus.eoc && n < EDGE_LIMIT);
    endtask

    task automatic completeConv(input string tag, input logic [7:0] expDout, input int expEdges);
        int n;
        waitEoc(n);
        checkOutput({tag, " latency"}, 32'(n), 32'(expEdges));
        checkOutput({tag, " dout"}, 32'(bus.dout), 32'(expDout));
        checkOutput({tag, " dout_valid"}, 32'(bus.dout_valid), 32'd1);
        checkOutput({tag, " trig count"}, 32'(trigCount), 32'(N_BITS));
        @(posedge clk);
        #1;
        checkOutput({tag, " dout_valid pulse"}, 32'(bus.dout_valid), 32'd0);
        checkOutput({tag, " eoc held"}, 32'(bus.eoc), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " eoc fall"}, 32'(bus.eoc), 32'd0);
    endtask

    task automatic waitTrigs(input int target, output int k);
        k = 0;
        for (int i = 0; i < EDGE_LIMIT && k < target; i++) begin
            @(negedge clk);
            if (bus.cmp_trig) k++;
        end
    endtask

    // Fail loudly rather than hang if the handshake ever wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        expSeq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst       = 1'b1;
        bus.start = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset dac_code", 32'(bus.dac_code), 32'd0);
        checkOutput("reset dout", 32'(bus.dout), 32'd0);
        checkOutput("reset dout_valid", 32'(bus.dout_valid), 32'd0);
        checkOutput("reset eoc", 32'(bus.eoc), 32'd0);
        checkOutput("reset cmp_trig", 32'(bus.cmp_trig), 32'd0);
        checkOutput("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'hA5, 0, -1);
        completeConv("ideal A5", 8'hA5, 16);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ideal trial code %0d", i), 32'(seqLog[i]), 32'(expSeq[i]));
        end

        applyStimulus(8'h00, 0, -1);
        completeConv("vin 00", 8'h00, 16);
        applyStimulus(8'hFF, 0, -1);
        completeConv("vin FF", 8'hFF, 16);

        applyStimulus(8'h3C, 3, -1);
        completeConv("delay 3", 8'h3C, 40);

        applyStimulus(8'hFF, 0, 2);
        completeConv("timeout bit5", 8'hDF, 30);
        checkOutput("timeout flag", 32'(bus.timeout_err), 32'd1);

        applyStimulus(8'h5A, 3, -1);
        #1;
        checkOutput("timeout cleared", 32'(bus.timeout_err), 32'd0);
        waitTrigs(5, k);
        checkOutput("abort reached bit3", 32'(k), 32'd5);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort dac_code", 32'(bus.dac_code), 32'd0);
        checkOutput("abort eoc", 32'(bus.eoc), 32'd0);
        checkOutput("abort dout kept", 32'(bus.dout), 32'hDF);
        checkOutput("abort dout_valid", 32'(bus.dout_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort no trig", 32'(bus.cmp_trig), 32'd0);

        applyStimulus(8'h77, 3, -1);
        waitTrigs(2, k);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset dac_code", 32'(bus.dac_code), 32'd0);
        checkOutput("midreset dout", 32'(bus.dout), 32'd0);
        checkOutput("midreset eoc", 32'(bus.eoc), 32'd0);
        checkOutput("midreset cmp_trig", 32'(bus.cmp_trig), 32'd0);
        checkOutput("midreset dout_valid", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        cmpDelay  = 0;
        trigCount = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset trig", 32'(bus.cmp_trig), 32'd1);
        checkOutput("post-reset dac_code", 32'(bus.dac_code), 32'h80);
        completeConv("post-reset", 8'h77, 16);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
